// File: rtl/spi_frame_scheduler.sv
// Round-robin scheduler that shares one 32-bit SPI slave transmit frame between up to
// four producers, each holding one pending 24-bit payload.
module spi_frame_scheduler #(
    parameter int NUM_SRC   = 4,
    parameter int PAYLOAD_W = 24
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         req,
    input  logic                         sched_en,
    input  logic [NUM_SRC-1:0]           src_valid,
    input  logic [NUM_SRC*PAYLOAD_W-1:0] src_payload,
    output logic [NUM_SRC-1:0]           src_ack,
    output logic [31:0]                  data_frame,
    output logic [7:0]                   overrun_cnt
);

    typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

    state_t               state;
    logic                 req_q;
    logic                 req_armed;
    logic [NUM_SRC-1:0]   pending;
    logic [PAYLOAD_W-1:0] payload [NUM_SRC];
    logic [1:0]           ptr;
    logic [4:0]           seq;

    logic                 req_rise;
    logic                 take_p0;
    logic                 found_p0;
    logic                 grant_vld_p0;
    logic [1:0]           grant_id_p0;
    logic [1:0]           cand;
    logic [NUM_SRC-1:0]   grant_vec;
    logic [2:0]           overrun_num;

    function automatic logic [7:0] sat_add_cnt(input logic [7:0] cnt, input logic [2:0] inc);
        logic [8:0] sum;
        sum = {1'b0, cnt} + {6'b0, inc};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

    // req_armed stays low after a reset taken with req high, so that held req cannot
    // masquerade as a fresh rising edge once reset is released.
    assign req_rise     = req & ~req_q & req_armed;
    assign take_p0      = (state == ST_IDLE) && req_rise;
    assign grant_vld_p0 = take_p0 && sched_en && found_p0;

    // Search order is ptr+1, ptr+2, ... wrapping modulo NUM_SRC.
    always_comb begin
        found_p0    = 1'b0;
        grant_id_p0 = ptr;
        cand        = ptr;
        for (int k = 1; k <= NUM_SRC; k++) begin
            cand = 2'((int'(ptr) + k) % NUM_SRC);
            if (!found_p0 && pending[cand]) begin
                found_p0    = 1'b1;
                grant_id_p0 = cand;
            end
        end
    end

    always_comb begin
        grant_vec   = '0;
        overrun_num = 3'd0;
        for (int i = 0; i < NUM_SRC; i++) begin
            grant_vec[i] = grant_vld_p0 && (grant_id_p0 == 2'(i));
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            if (src_valid[i] && pending[i] && !grant_vec[i]) begin
                overrun_num = overrun_num + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            req_q       <= 1'b0;
            req_armed   <= ~req;
            pending     <= '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                payload[i] <= '0;
            end
            ptr         <= 2'(NUM_SRC - 1);
            seq         <= 5'd0;
            overrun_cnt <= 8'd0;
            src_ack     <= '0;
            data_frame  <= 32'h0000_0000;
        end else begin
            req_q       <= req;
            if (!req) begin
                req_armed <= 1'b1;
            end
            src_ack     <= grant_vec;
            overrun_cnt <= sat_add_cnt(overrun_cnt, overrun_num);

            // A load on the slot being granted wins: new payload kept, pending stays set.
            for (int i = 0; i < NUM_SRC; i++) begin
                if (grant_vec[i]) begin
                    pending[i] <= 1'b0;
                end
                if (src_valid[i]) begin
                    payload[i] <= src_payload[i*PAYLOAD_W +: PAYLOAD_W];
                    pending[i] <= 1'b1;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (req_rise) begin
                        state <= ST_ACTIVE;
                        if (grant_vld_p0) begin
                            data_frame <= {1'b1, grant_id_p0, seq, payload[grant_id_p0]};
                            ptr        <= grant_id_p0;
                            seq        <= seq + 5'd1;
                        end else begin
                            data_frame <= {1'b0, 2'b00, seq, {PAYLOAD_W{1'b0}}};
                        end
                    end
                end
                ST_ACTIVE: begin
                    if (!req) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_frame_scheduler.sv
// Bench for spi_frame_scheduler: directed scenarios followed by random traffic, checked
// every cycle against a transaction-level model of slots, pointer and sequence number.
module tb_spi_frame_scheduler;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         req;
    logic         sched_en;
    logic [N-1:0] src_valid;
    logic [N*24-1:0] src_payload;
    logic [N-1:0] src_ack;
    logic [31:0]  data_frame;
    logic [7:0]   overrun_cnt;

    int checks = 0;
    int errors = 0;

    spi_frame_scheduler #(.NUM_SRC(N), .PAYLOAD_W(24)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .sched_en    (sched_en),
        .src_valid   (src_valid),
        .src_payload (src_payload),
        .src_ack     (src_ack),
        .data_frame  (data_frame),
        .overrun_cnt (overrun_cnt)
    );

    always #5 clk = ~clk;

    // Reference model state
    bit          m_pend [N];
    logic [23:0] m_pay  [N];
    int          m_ptr;
    int          m_seq;
    int          m_ovr;
    logic [31:0] m_frame;
    logic [3:0]  m_ack;
    bit          m_txn;
    bit          m_armed;
    bit          m_prev;

    task automatic model_step();
        int gid;
        bit start;
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                m_pend[i] = 0;
                m_pay[i]  = '0;
            end
            m_ptr = N - 1; m_seq = 0; m_ovr = 0;
            m_frame = '0; m_ack = '0; m_txn = 0;
            m_armed = !req; m_prev = 0;
            return;
        end
        start = req && !m_prev && m_armed && !m_txn;
        m_ack = '0;
        gid = -1;
        if (start) begin
            if (sched_en) begin
                for (int k = 1; k <= N; k++) begin
                    if (gid < 0 && m_pend[(m_ptr + k) % N]) gid = (m_ptr + k) % N;
                end
            end
            if (gid >= 0) begin
                m_frame = {1'b1, 2'(gid), 5'(m_seq), m_pay[gid]};
                m_ack[gid] = 1'b1;
                m_pend[gid] = 0;
                m_ptr = gid;
                m_seq = (m_seq + 1) % 32;
            end else begin
                m_frame = {1'b0, 2'b00, 5'(m_seq), 24'h0};
            end
            m_txn = 1;
        end else if (m_txn && !req) begin
            m_txn = 0;
        end
        for (int i = 0; i < N; i++) begin
            if (src_valid[i]) begin
                if (m_pend[i] && i != gid && m_ovr < 255) m_ovr++;
                m_pay[i]  = src_payload[i*24 +: 24];
                m_pend[i] = 1;
            end
        end
        if (!req) m_armed = 1;
        m_prev = req;
    endtask

    task automatic expect_eq(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all(string tag);
        expect_eq({tag, "_frame"}, data_frame, m_frame);
        expect_eq({tag, "_ack"}, 32'(src_ack), 32'(m_ack));
        expect_eq({tag, "_ovr"}, 32'(overrun_cnt), 32'(m_ovr));
    endtask

    // Starts and ends on a falling edge; inputs are applied there, outputs checked there.
    task automatic step(string tag, logic [N-1:0] v, logic [N*24-1:0] pl);
        src_valid = v;
        src_payload = pl;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all(tag);
        src_valid = '0;
    endtask

    task automatic load(string tag, int slot, logic [23:0] p);
        logic [N*24-1:0] pl;
        logic [N-1:0] v;
        pl = '0;
        v = '0;
        pl[slot*24 +: 24] = p;
        v[slot] = 1'b1;
        step(tag, v, pl);
    endtask

    task automatic pulse(string tag, int hold, output logic [31:0] f, output logic [3:0] a);
        req = 1'b1;
        step(tag, '0, '0);
        f = data_frame;
        a = src_ack;
        for (int k = 1; k < hold; k++) step(tag, '0, '0);
        req = 1'b0;
        step(tag, '0, '0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] f;
        logic [3:0]  a;
        logic [31:0] first;
        logic [31:0] exp_seq [5];
        int          ack_cycles;
        int          ovr_before;
        logic [N-1:0] v;

        reset = 1'b1; req = 1'b0; sched_en = 1'b1; src_valid = '0; src_payload = '0;
        @(negedge clk);
        step("rst", '0, '0);
        step("rst", '0, '0);
        expect_eq("rst_frame", data_frame, 32'h0);
        expect_eq("rst_ack", 32'(src_ack), 32'h0);
        reset = 1'b0;
        step("idle", '0, '0);

        pulse("empty", 2, f, a);
        expect_eq("empty_frame", f, 32'h0000_0000);
        expect_eq("empty_ack", 32'(a), 32'h0);

        load("l2", 2, 24'hABCDEF);
        pulse("g2", 2, f, a);
        expect_eq("g2_frame", f, 32'hC0AB_CDEF);
        expect_eq("g2_ack", 32'(a), 32'h4);
        pulse("seq1", 1, f, a);
        expect_eq("seq1_frame", f, 32'h0100_0000);

        // All four slots, granted in order then idle
        reset = 1'b1; step("rst", '0, '0); reset = 1'b0;
        step("lall", 4'hF, {24'h4, 24'h3, 24'h2, 24'h1});
        exp_seq = '{32'h8000_0001, 32'hA100_0002, 32'hC200_0003, 32'hE300_0004, 32'h0400_0000};
        for (int k = 0; k < 5; k++) begin
            pulse("rr", 1, f, a);
            expect_eq("rr_order", f, exp_seq[k]);
        end

        // Overruns and saturation
        load("ov", 1, 24'h111111);
        load("ov", 1, 24'h111112);
        load("ov", 1, 24'h111113);
        expect_eq("ov_cnt2", 32'(overrun_cnt), 32'd2);
        pulse("ov_g", 1, f, a);
        expect_eq("ov_frame", f, 32'hA411_1113);
        for (int k = 0; k < 258; k++) load("sat", 0, 24'($urandom));
        expect_eq("ov_sat", 32'(overrun_cnt), 32'd255);

        // req held high for 10 cycles grants once
        reset = 1'b1; step("rst", '0, '0); reset = 1'b0;
        step("l01", 4'b0011, {24'h0, 24'h0, 24'h0B0B0B, 24'h0A0A0A});
        req = 1'b1;
        step("hold", '0, '0);
        first = data_frame;
        ack_cycles = (src_ack != 0) ? 1 : 0;
        for (int k = 1; k < 10; k++) begin
            step("hold", '0, '0);
            expect_eq("hold_stable", data_frame, first);
            if (src_ack != 0) ack_cycles++;
        end
        expect_eq("hold_first", first, 32'h800A_0A0A);
        expect_eq("hold_acks", 32'(ack_cycles), 32'd1);
        req = 1'b0;
        step("hold", '0, '0);
        pulse("hold2", 1, f, a);
        expect_eq("hold2_frame", f, 32'hA10B_0B0B);

        // Scheduling disabled keeps slots
        sched_en = 1'b0;
        load("l3", 3, 24'h333333);
        pulse("dis", 1, f, a);
        expect_eq("dis_frame", f, 32'h0200_0000);
        sched_en = 1'b1;
        pulse("en", 1, f, a);
        expect_eq("en_frame", f, 32'hE233_3333);
        expect_eq("en_ack", 32'(a), 32'h8);

        // Grant and load on the same slot in the same cycle
        load("gl", 0, 24'h000AAA);
        ovr_before = int'(overrun_cnt);
        req = 1'b1;
        step("gl", 4'b0001, {24'h0, 24'h0, 24'h0, 24'h000BBB});
        expect_eq("gl_frame", data_frame, 32'h8300_0AAA);
        expect_eq("gl_ovr", 32'(overrun_cnt), 32'(ovr_before));
        step("gl", '0, '0);
        req = 1'b0;
        step("gl", '0, '0);
        pulse("gl2", 1, f, a);
        expect_eq("gl2_frame", f, 32'h8400_0BBB);

        // Reset while active with req high
        load("ra", 2, 24'h0C0C0C);
        req = 1'b1;
        step("ra", '0, '0);
        step("ra", '0, '0);
        reset = 1'b1; step("ra_rst", '0, '0); reset = 1'b0;
        load("ra_l1", 1, 24'h0D0D0D);
        for (int k = 0; k < 3; k++) begin
            step("ra_hi", '0, '0);
            expect_eq("ra_frame0", data_frame, 32'h0);
            expect_eq("ra_noack", 32'(src_ack), 32'h0);
        end
        req = 1'b0;
        step("ra", '0, '0);
        pulse("ra2", 1, f, a);
        expect_eq("ra2_frame", f, 32'hA00D_0D0D);

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 3) == 0) req = ~req;
            sched_en = ($urandom_range(0, 7) != 0);
            reset = ($urandom_range(0, 199) == 0);
            for (int j = 0; j < N; j++) v[j] = ($urandom_range(0, 3) == 0);
            step("rnd", v, {$urandom, $urandom, $urandom});
        end
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
